// File: rtl/csr_std_bank.sv
// Bank of NUM_CSR standard CSRs with privilege and read-only address checks,
// per-bit write protection, a one-deep response register and change strobes.
module csr_std_bank #(
  parameter int                      NUM_CSR     = 4,
  parameter int                      RSZ         = 32,
  parameter int                      SZ          = RSZ,
  parameter logic [11:0]             BASE_ADDR   = 12'h300,
  parameter logic [NUM_CSR*SZ-1:0]   INIT_VALUES = {(NUM_CSR*SZ){1'b0}},
  parameter logic [NUM_CSR*SZ-1:0]   ROMASK      = {(NUM_CSR*SZ){1'b0}}
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic [1:0]              mode,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [11:0]             req_addr,
  input  logic [1:0]              req_op,
  input  logic [SZ-1:0]           req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SZ-1:0]           rsp_rdata,
  output logic                    rsp_illegal,
  output logic [NUM_CSR*SZ-1:0]   csr_q,
  output logic [NUM_CSR-1:0]      csr_chg
);

  logic [NUM_CSR-1:0][SZ-1:0] csr_r;
  logic [NUM_CSR-1:0]         csr_chg_r;
  logic                       rsp_valid_r;
  logic [SZ-1:0]              rsp_rdata_r;
  logic                       rsp_illegal_r;

  logic                       accept_s;
  logic [11:0]                offset_s;
  logic                       hit_s;
  logic                       wi_s;
  logic                       illegal_s;
  logic [NUM_CSR-1:0]         sel_s;
  logic [SZ-1:0]              old_s;
  logic [SZ-1:0]              ro_s;
  logic [SZ-1:0]              cand_s;
  logic [SZ-1:0]              new_s;
  logic                       do_write_s;
  logic                       changed_s;

  assign req_ready   = !rsp_valid_r || rsp_ready;
  assign accept_s    = req_valid && req_ready;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_illegal = rsp_illegal_r;
  assign csr_q       = csr_r;
  assign csr_chg     = csr_chg_r;

  // Decode the request: address hit, legality, selected entry and its next value.
  always_comb begin
    offset_s  = req_addr - BASE_ADDR;
    hit_s     = (req_addr >= BASE_ADDR) && (offset_s < 12'(NUM_CSR));
    // Set/clear with an empty mask degenerates to a read and escapes the RO-space check.
    wi_s      = (req_op == 2'b01) || (req_op[1] && (req_wdata != {SZ{1'b0}}));
    illegal_s = !hit_s || (mode < req_addr[9:8]) || (wi_s && (req_addr[11:10] == 2'b11));
    old_s     = {SZ{1'b0}};
    ro_s      = {SZ{1'b0}};
    sel_s     = {NUM_CSR{1'b0}};
    for (int i = 0; i < NUM_CSR; i++) begin
      sel_s[i] = (offset_s == 12'(i));
      old_s    = old_s | (csr_r[i] & {SZ{sel_s[i]}});
      ro_s     = ro_s | (ROMASK[i*SZ +: SZ] & {SZ{sel_s[i]}});
    end
    case (req_op)
      2'b01:   cand_s = req_wdata;
      2'b10:   cand_s = old_s | req_wdata;
      2'b11:   cand_s = old_s & ~req_wdata;
      default: cand_s = old_s;
    endcase
    new_s      = (old_s & ro_s) | (cand_s & ~ro_s);
    do_write_s = accept_s && !illegal_s && wi_s;
    changed_s  = do_write_s && (new_s != old_s);
  end

  // CSR storage, response register and change strobes.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      csr_r         <= INIT_VALUES;
      csr_chg_r     <= {NUM_CSR{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {SZ{1'b0}};
      rsp_illegal_r <= 1'b0;
    end else begin
      csr_chg_r <= {NUM_CSR{1'b0}};
      if (accept_s) begin
        rsp_valid_r   <= 1'b1;
        rsp_illegal_r <= illegal_s;
        rsp_rdata_r   <= illegal_s ? {SZ{1'b0}} : old_s;
        csr_chg_r     <= changed_s ? sel_s : {NUM_CSR{1'b0}};
        for (int i = 0; i < NUM_CSR; i++) begin
          if (do_write_s && sel_s[i]) begin
            csr_r[i] <= new_s;
          end
        end
      end else if (rsp_ready) begin
        rsp_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/csr_std_bank.md
CSR_STD_BANK -- requirements
Module: csr_std_bank

Interface
REQ-001 Parameter NUM_CSR, default 4: number of CSRs in the bank, range 1..16.
REQ-002 Parameter SZ, default RSZ: width of each CSR in bits.
REQ-003 Parameter BASE_ADDR, default 12'h300: 12-bit CSR address of entry 0; entry i is at BASE_ADDR+i.
REQ-004 Parameter INIT_VALUES, default 0: packed NUM_CSR*SZ reset values; entry i is at bits [i*SZ +: SZ].
REQ-005 Parameter ROMASK, default 0: packed NUM_CSR*SZ read-only bit masks; a 1 marks a bit that software cannot write.
REQ-006 clk_in  input  1  single clock; all state updates on the rising edge.
REQ-007 reset_in  input  1  asynchronous, active-high reset.
REQ-008 mode  input  2  current privilege level (0=U, 1=S, 3=M).
REQ-009 req_valid  input  1  request present.
REQ-010 req_ready  output  1  bank can accept a request this cycle.
REQ-011 req_addr  input  12  CSR address.
REQ-012 req_op  input  2  operation: 00 read, 01 write, 10 set, 11 clear.
REQ-013 req_wdata  input  SZ  write data, or set/clear mask.
REQ-014 rsp_valid  output  1  response present.
REQ-015 rsp_ready  input  1  consumer accepts the response.
REQ-016 rsp_rdata  output  SZ  CSR value before the access; 0 when the access is illegal.
REQ-017 rsp_illegal  output  1  access rejected.
REQ-018 csr_q  output  NUM_CSR*SZ  current value of every CSR, packed by entry.
REQ-019 csr_chg  output  NUM_CSR  one-cycle strobe per entry, high when that entry's value changed.

Function
REQ-020 req_ready SHALL equal (!rsp_valid | rsp_ready), evaluated combinationally.
REQ-021 A request is accepted on a rising edge where req_valid & req_ready; the response SHALL appear on the next cycle (latency 1).
REQ-022 A response SHALL hold rsp_valid, rsp_rdata and rsp_illegal stable until the cycle it is accepted (rsp_valid & rsp_ready).
REQ-023 A response accepted in the same cycle as a new request SHALL be replaced back-to-back by the new response, with no bubble cycle.
REQ-024 Hit: BASE_ADDR <= req_addr <= BASE_ADDR+NUM_CSR-1, compared as unsigned 12-bit values; idx = req_addr - BASE_ADDR.
REQ-025 The request SHALL be a write-intent request when req_op==01, or when req_op is 10 or 11 with req_wdata != 0.
REQ-026 Set or clear with req_wdata==0 SHALL behave exactly as a read.
REQ-027 The access SHALL be illegal when any of the following holds: it is not a hit; mode < req_addr[9:8] (unsigned); or it is a write-intent request and req_addr[11:10]==2'b11.
REQ-028 An illegal access SHALL produce rsp_illegal=1 and rsp_rdata=0, and SHALL leave all CSRs and csr_chg unchanged.
REQ-029 For a legal access, rsp_rdata SHALL equal the CSR value before the update, and rsp_illegal=0.
REQ-030 A legal write-intent access SHALL compute a candidate value: write = wdata; set = old | wdata; clear = old & ~wdata.
REQ-031 The stored value SHALL be (old & ROMASK_i) | (candidate & ~ROMASK_i); it is written in the same edge that accepts the request.
REQ-032 csr_chg[idx] SHALL pulse high for exactly the cycle after acceptance if and only if the stored value differs from old; all other bits of csr_chg SHALL stay 0.
REQ-033 A read SHALL never modify any CSR or assert csr_chg.
REQ-034 At most one CSR SHALL update per cycle.
REQ-035 csr_q SHALL reflect the update on the cycle after acceptance, so back-to-back requests to the same CSR see the prior update.
REQ-036 While rsp_valid=1 and rsp_ready=0, the bank SHALL accept no request and update no CSR.

Reset
REQ-037 While reset_in is high, asynchronously and regardless of clk_in: csr_q SHALL equal INIT_VALUES, and rsp_valid, rsp_illegal, rsp_rdata and csr_chg SHALL all be 0.
REQ-038 A reset asserted while a response is pending SHALL discard that response; no CSR write SHALL survive reset.
REQ-039 The first request SHALL be accepted on the first rising edge after reset_in deasserts, provided req_valid is high.

Verification
REQ-040 NUM_CSR=4, BASE=12'h300, INIT entry1=32'h0000_00F0, mode=3, rsp_ready=1; op=set addr 301 wdata 0F -> next cycle rsp_rdata=F0, csr1=FF, csr_chg=4'b0010.
REQ-041 ROMASK entry0=32'hFFFF_0000; op=write addr 300 wdata FFFF_FFFF -> csr0=0000_FFFF; repeat the same write -> rsp_rdata=0000_FFFF, csr_chg=0.
REQ-042 mode=0, op=write addr 300 -> rsp_illegal=1, rsp_rdata=0, csr unchanged; then addr 304 with mode=3 -> rsp_illegal=1 (out of range).
REQ-043 Instantiate with BASE=12'hC00 and mode=3: op=set wdata 0 -> legal read; op=set wdata 1 -> rsp_illegal=1.
REQ-044 Hold rsp_ready=0 for 3 cycles with req_valid high -> req_ready=0, response stable, no CSR change; release -> next request accepted the same cycle.
REQ-045 Assert reset_in mid-response -> rsp_valid=0 and csr_q=INIT_VALUES immediately, without waiting for a clock edge.
